wb_arbiter2: RTL and testbench
==============================

Name: wb_arbiter2

Overview:
- Two-master, one-slave Wishbone B4 classic arbiter placed between CPU-side bus masters and the shared RAM/device bus.
- M0 is the data-side master and M1 is the fetch or debug master; each is a bus adapter that holds CYC/STB until ACK.
- Grants the slave bus to one master per transaction, routes ACK only to the owner, and terminates hung cycles with a timeout error.

Parameters:
FIXED_PRIO, 0, 0 = round-robin on contention; 1 = M0 always wins ties
TIMEOUT, 255, cycles a granted transaction may wait for slave ACK before forced termination (1..65535)

Ports:
CLK_I  in  1  system clock, all logic on rising edge
RST_I  in  1  synchronous, active-high reset
M0_CYC_I / M1_CYC_I  in  1 each  master cycle request
M0_STB_I / M1_STB_I  in  1 each  master strobe
M0_WE_I / M1_WE_I  in  1 each  master write enable
M0_ADR_I / M1_ADR_I  in  32 each  master address
M0_DAT_I / M1_DAT_I  in  32 each  master write data
M0_SEL_I / M1_SEL_I  in  4 each  master byte selects
M0_DAT_O / M1_DAT_O  out  32 each  read data, both driven from S_DAT_I
M0_ACK_O / M1_ACK_O  out  1 each  ACK, gated to owner only
M0_ERR_O / M1_ERR_O  out  1 each  one-cycle timeout error, coincident with that master's ACK
S_CYC_O, S_STB_O, S_WE_O  out  1  slave control, muxed from owner
S_ADR_O  out  32  slave address
S_DAT_O  out  32  slave write data
S_SEL_O  out  4  slave byte selects
S_DAT_I  in  32  slave read data
S_ACK_I  in  1  slave acknowledge
O_grant  out  2  one-hot owner: 00 idle, 01 M0, 10 M1
O_timeout  out  1  one-cycle pulse when a timeout fires

Behaviour:
- States: IDLE, OWN0, OWN1.
- Registers: state, last-owner bit, timeout counter (width clog2(TIMEOUT+1)).
- Reset (RST_I high at clock edge):
  - state=IDLE, last=1 so M0 wins the first tie, counter=0.
  - While RST_I is high, all S_* control, ACK, ERR and O_timeout are forced 0.
  - O_grant=00.
- IDLE: sample the CYC&STB requests.
  - Only M0 requests -> OWN0. Only M1 requests -> OWN1.
  - Both request, FIXED_PRIO=1 -> OWN0.
  - Both request, FIXED_PRIO=0 -> the master not equal to last.
  - Grant latency is 1 cycle: a request first seen at cycle n reaches the slave at n+1.
- OWNx:
  - S_* outputs = Mx inputs (combinational mux on the registered state); non-owner inputs are ignored.
  - Mx_ACK_O = S_ACK_I. The other master's ACK = 0.
  - Exit to IDLE on the next edge when any of these holds:
    - S_ACK_I=1 (normal completion);
    - Mx_CYC_I=0 (master abort);
    - counter reaches TIMEOUT-1 with no ACK.
  - On exit: last<=x, counter<=0. Each owned cycle without ACK increments the counter.
- Timeout:
  - In the exit cycle, drive Mx_ACK_O=1, Mx_ERR_O=1, O_timeout=1, and force S_CYC_O/S_STB_O=0.
  - A late slave ACK after this point is dropped.
- IDLE forces S_CYC_O=S_STB_O=S_WE_O=0 and S_SEL_O=0. S_ADR_O/S_DAT_O are don't-care but driven 0.
- Back-to-back:
  - After ACK there is one mandatory IDLE cycle, which lets the master's registered CYC drop.
  - Each master therefore gets at most one transaction per 2+ cycles; under contention, round-robin alternates strictly.
- Simultaneous ACK and timeout expiry in the same cycle: treat as normal ACK, ERR=0.
- Reset mid-transaction: ownership drops immediately; no ACK is issued to the owner.

Decomposition:
- Shared package/header busdefs: grant encoding constants (GRANT_NONE/M0/M1) and state encodings.
- A single sub-module, wb_timeout_cnt (load/clear, enable, expire output), is natural.
- The mux and FSM stay in wb_arbiter2.

Test Plan:
- M0 alone reads 0x1000, slave ACKs 3 cycles after S_STB_O -> O_grant=01 one cycle after request; M0_DAT_O=S_DAT_I in the ACK cycle; M1_ACK_O stays 0; back to 00 next cycle.
- M0 and M1 request in the same cycle from reset, FIXED_PRIO=0 -> M0 served first, then M1. Repeat with both held -> grants alternate 01,00,10,00,01.
- FIXED_PRIO=1, both continuously requesting -> M1 never granted while M0 holds CYC.
- M1 write 0xDEADBEEF to 0x2004, SEL=1111, slave never ACKs, TIMEOUT=16 -> on the 16th owned cycle M1_ACK_O=M1_ERR_O=O_timeout=1 and S_CYC_O=0. A slave ACK one cycle later is not forwarded.
- M0 granted, then M0 drops CYC with no ACK -> IDLE next cycle, no ACK/ERR emitted, counter cleared.
- RST_I asserted during the OWN1 wait -> next cycle O_grant=00, S_CYC_O=0, M1_ACK_O=0. After release, a pending M0 request is granted first.

Source files
------------

// File: rtl/wb_arbiter2_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: grant codes and FSM state encodings.
package wb_arbiter2_pkg;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  function automatic logic [1:0] state_grant(input logic [1:0] st);
    case (st)
      ST_OWN0: state_grant = GRANT_M0;
      ST_OWN1: state_grant = GRANT_M1;
      default: state_grant = GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Counts owned cycles without ACK; expire_o flags the last cycle a transaction may wait.
module wb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == LIMIT);

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone B4 classic arbiter with round-robin or fixed priority
// and a per-transaction ACK timeout that terminates hung cycles with an error.
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        M0_CYC_I,
  input  logic        M0_STB_I,
  input  logic        M0_WE_I,
  input  logic [31:0] M0_ADR_I,
  input  logic [31:0] M0_DAT_I,
  input  logic [3:0]  M0_SEL_I,
  output logic [31:0] M0_DAT_O,
  output logic        M0_ACK_O,
  output logic        M0_ERR_O,
  input  logic        M1_CYC_I,
  input  logic        M1_STB_I,
  input  logic        M1_WE_I,
  input  logic [31:0] M1_ADR_I,
  input  logic [31:0] M1_DAT_I,
  input  logic [3:0]  M1_SEL_I,
  output logic [31:0] M1_DAT_O,
  output logic        M1_ACK_O,
  output logic        M1_ERR_O,
  output logic        S_CYC_O,
  output logic        S_STB_O,
  output logic        S_WE_O,
  output logic [31:0] S_ADR_O,
  output logic [31:0] S_DAT_O,
  output logic [3:0]  S_SEL_O,
  input  logic [31:0] S_DAT_I,
  input  logic        S_ACK_I,
  output logic [1:0]  O_grant,
  output logic        O_timeout
);

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;
  logic       owning, sel1, drive, done, tmo_fire, cnt_expire;
  logic       req0, req1;
  logic       o_cyc, o_stb, o_we;
  logic [31:0] o_adr, o_dat;
  logic [3:0]  o_sel;

  assign req0   = M0_CYC_I & M0_STB_I;
  assign req1   = M1_CYC_I & M1_STB_I;
  assign owning = (state_q == ST_OWN0) | (state_q == ST_OWN1);
  assign sel1   = (state_q == ST_OWN1);
  assign drive  = owning & ~RST_I;

  assign o_cyc = sel1 ? M1_CYC_I : M0_CYC_I;
  assign o_stb = sel1 ? M1_STB_I : M0_STB_I;
  assign o_we  = sel1 ? M1_WE_I  : M0_WE_I;
  assign o_adr = sel1 ? M1_ADR_I : M0_ADR_I;
  assign o_dat = sel1 ? M1_DAT_I : M0_DAT_I;
  assign o_sel = sel1 ? M1_SEL_I : M0_SEL_I;

  // A coincident ACK wins over expiry; an aborted cycle gets no error.
  assign tmo_fire = drive & cnt_expire & ~S_ACK_I & o_cyc;
  assign done     = owning & (S_ACK_I | ~o_cyc | cnt_expire);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (!owning) begin
      state_d = ST_IDLE;
      if (req0 && req1) begin
        if (FIXED_PRIO != 0) state_d = ST_OWN0;
        else                 state_d = last_q ? ST_OWN0 : ST_OWN1;
      end else if (req0) begin
        state_d = ST_OWN0;
      end else if (req1) begin
        state_d = ST_OWN1;
      end
    end else if (done) begin
      state_d = ST_IDLE;
      last_d  = sel1;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_i    (CLK_I),
    .rst_i    (RST_I),
    .clr_i    (~owning | done),
    .en_i     (owning & ~done),
    .expire_o (cnt_expire)
  );

  always_comb begin
    S_CYC_O   = drive & o_cyc & ~tmo_fire;
    S_STB_O   = drive & o_stb & ~tmo_fire;
    S_WE_O    = drive & o_we;
    S_ADR_O   = drive ? o_adr : '0;
    S_DAT_O   = drive ? o_dat : '0;
    S_SEL_O   = drive ? o_sel : '0;
    M0_ACK_O  = drive & ~sel1 & (S_ACK_I | tmo_fire);
    M1_ACK_O  = drive &  sel1 & (S_ACK_I | tmo_fire);
    M0_ERR_O  = ~sel1 & tmo_fire;
    M1_ERR_O  =  sel1 & tmo_fire;
    O_timeout = tmo_fire;
    O_grant   = RST_I ? GRANT_NONE : state_grant(state_q);
    M0_DAT_O  = S_DAT_I;
    M1_DAT_O  = S_DAT_I;
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Checks two arbiter instances (round-robin/TIMEOUT=16, fixed-priority/TIMEOUT=5) every cycle
// against a transaction-level ownership model, with directed scenarios then random traffic.
module tb_wb_arbiter2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mcyc[2], mstb[2], mwe[2];
  logic [31:0] madr[2], mdat[2];
  logic [3:0]  msel[2];
  logic        s_ack;
  logic [31:0] s_dat;

  logic [1:0]  grant[2];
  logic        scyc[2], sstb[2], swe[2], tmo[2];
  logic        ack0[2], ack1[2], err0[2], err1[2];
  logic [31:0] sadr[2], sdato[2], dat0[2], dat1[2];
  logic [3:0]  ssel[2];

  wb_arbiter2 #(.FIXED_PRIO(0), .TIMEOUT(16)) u_rr (
    .CLK_I(clk), .RST_I(rst),
    .M0_CYC_I(mcyc[0]), .M0_STB_I(mstb[0]), .M0_WE_I(mwe[0]), .M0_ADR_I(madr[0]),
    .M0_DAT_I(mdat[0]), .M0_SEL_I(msel[0]), .M0_DAT_O(dat0[0]), .M0_ACK_O(ack0[0]), .M0_ERR_O(err0[0]),
    .M1_CYC_I(mcyc[1]), .M1_STB_I(mstb[1]), .M1_WE_I(mwe[1]), .M1_ADR_I(madr[1]),
    .M1_DAT_I(mdat[1]), .M1_SEL_I(msel[1]), .M1_DAT_O(dat1[0]), .M1_ACK_O(ack1[0]), .M1_ERR_O(err1[0]),
    .S_CYC_O(scyc[0]), .S_STB_O(sstb[0]), .S_WE_O(swe[0]), .S_ADR_O(sadr[0]), .S_DAT_O(sdato[0]),
    .S_SEL_O(ssel[0]), .S_DAT_I(s_dat), .S_ACK_I(s_ack), .O_grant(grant[0]), .O_timeout(tmo[0])
  );

  wb_arbiter2 #(.FIXED_PRIO(1), .TIMEOUT(5)) u_fp (
    .CLK_I(clk), .RST_I(rst),
    .M0_CYC_I(mcyc[0]), .M0_STB_I(mstb[0]), .M0_WE_I(mwe[0]), .M0_ADR_I(madr[0]),
    .M0_DAT_I(mdat[0]), .M0_SEL_I(msel[0]), .M0_DAT_O(dat0[1]), .M0_ACK_O(ack0[1]), .M0_ERR_O(err0[1]),
    .M1_CYC_I(mcyc[1]), .M1_STB_I(mstb[1]), .M1_WE_I(mwe[1]), .M1_ADR_I(madr[1]),
    .M1_DAT_I(mdat[1]), .M1_SEL_I(msel[1]), .M1_DAT_O(dat1[1]), .M1_ACK_O(ack1[1]), .M1_ERR_O(err1[1]),
    .S_CYC_O(scyc[1]), .S_STB_O(sstb[1]), .S_WE_O(swe[1]), .S_ADR_O(sadr[1]), .S_DAT_O(sdato[1]),
    .S_SEL_O(ssel[1]), .S_DAT_I(s_dat), .S_ACK_I(s_ack), .O_grant(grant[1]), .O_timeout(tmo[1])
  );

  // Reference model: owner 0 = nobody, 1 = M0, 2 = M1; last = index of master served last.
  int fixed_prio[2] = '{0, 1};
  int limit[2]      = '{16, 5};
  int owner[2];
  int last[2];
  int waited[2];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[u%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic check_inst(input int k);
    bit          own, fire;
    int          m;
    logic [1:0]  e_grant;
    own  = !rst && owner[k] != 0;
    m    = own ? owner[k] - 1 : 0;
    fire = own && waited[k] == limit[k] - 1 && !s_ack && mcyc[m];
    e_grant = !own ? 2'b00 : (m == 0 ? 2'b01 : 2'b10);
    chk("grant",   k, 32'(grant[k]), 32'(e_grant));
    chk("s_cyc",   k, 32'(scyc[k]),  32'(own && mcyc[m] && !fire));
    chk("s_stb",   k, 32'(sstb[k]),  32'(own && mstb[m] && !fire));
    chk("s_we",    k, 32'(swe[k]),   32'(own && mwe[m]));
    chk("s_adr",   k, sadr[k],       own ? madr[m] : 32'h0);
    chk("s_dat",   k, sdato[k],      own ? mdat[m] : 32'h0);
    chk("s_sel",   k, 32'(ssel[k]),  own ? 32'(msel[m]) : 32'h0);
    chk("m0_ack",  k, 32'(ack0[k]),  32'(own && m == 0 && (s_ack || fire)));
    chk("m1_ack",  k, 32'(ack1[k]),  32'(own && m == 1 && (s_ack || fire)));
    chk("m0_err",  k, 32'(err0[k]),  32'(fire && m == 0));
    chk("m1_err",  k, 32'(err1[k]),  32'(fire && m == 1));
    chk("timeout", k, 32'(tmo[k]),   32'(fire));
    chk("m0_dat",  k, dat0[k],       s_dat);
    chk("m1_dat",  k, dat1[k],       s_dat);
  endtask

  task automatic model_step(input int k);
    bit r0, r1;
    int m;
    r0 = mcyc[0] && mstb[0];
    r1 = mcyc[1] && mstb[1];
    if (rst) begin
      owner[k] = 0; last[k] = 1; waited[k] = 0;
    end else if (owner[k] == 0) begin
      if (r0 && r1)  owner[k] = (fixed_prio[k] != 0 || last[k] == 1) ? 1 : 2;
      else if (r0)   owner[k] = 1;
      else if (r1)   owner[k] = 2;
    end else begin
      m = owner[k] - 1;
      if (s_ack || !mcyc[m] || waited[k] == limit[k] - 1) begin
        last[k] = m; owner[k] = 0; waited[k] = 0;
      end else begin
        waited[k]++;
      end
    end
  endtask

  task automatic cycle(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_inst(0);
      check_inst(1);
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
    end
  endtask

  task automatic set_master(input int j, input logic cyc, input logic stb, input logic we,
                            input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    mcyc[j] = cyc; mstb[j] = stb; mwe[j] = we; madr[j] = adr; mdat[j] = dat; msel[j] = sel;
  endtask

  initial begin
    owner = '{0, 0}; last = '{1, 1}; waited = '{0, 0};
    rst = 1'b1; s_ack = 1'b0; s_dat = 32'h0;
    set_master(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    set_master(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    #1;
    cycle(2);
    rst = 1'b0;
    cycle(1);

    // M0 alone reads 0x1000, slave ACKs after three wait cycles
    set_master(0, 1, 1, 0, 32'h0000_1000, 32'h0, 4'hF);
    cycle(4);
    s_ack = 1'b1; s_dat = 32'hCAFE_0123;
    cycle(1);
    s_ack = 1'b0;
    set_master(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    cycle(2);

    // Simultaneous requests from reset, held, slave ACKs immediately
    rst = 1'b1;
    cycle(1);
    rst = 1'b0;
    set_master(0, 1, 1, 1, 32'h0000_0100, 32'h1111_1111, 4'h3);
    set_master(1, 1, 1, 0, 32'h0000_0200, 32'h2222_2222, 4'hC);
    s_ack = 1'b1; s_dat = 32'h5555_AAAA;
    cycle(9);
    s_ack = 1'b0;
    set_master(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    set_master(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    cycle(2);

    // M1 write to a slave that never answers; a late ACK follows the timeout
    set_master(1, 1, 1, 1, 32'h0000_2004, 32'hDEAD_BEEF, 4'hF);
    cycle(17);
    s_ack = 1'b1;
    set_master(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    cycle(1);
    s_ack = 1'b0;
    cycle(2);

    // M0 abort without ACK
    set_master(0, 1, 1, 0, 32'h0000_3000, 32'h0, 4'h1);
    cycle(2);
    set_master(0, 0, 0, 0, 32'h0000_3000, 32'h0, 4'h1);
    cycle(3);

    // Reset while M1 waits, with M0 pending
    set_master(1, 1, 1, 0, 32'h0000_4000, 32'h0, 4'hF);
    cycle(3);
    set_master(0, 1, 1, 1, 32'h0000_5000, 32'h7777_8888, 4'h6);
    rst = 1'b1;
    cycle(1);
    rst = 1'b0;
    cycle(3);
    s_ack = 1'b1;
    cycle(1);
    s_ack = 1'b0;
    set_master(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    set_master(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    cycle(2);

    // Random traffic, including rare resets and sparse slave ACKs
    for (int n = 0; n < 3000; n++) begin
      for (int j = 0; j < 2; j++)
        set_master(j, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 1'($urandom),
                   $urandom, $urandom, 4'($urandom_range(0, 15)));
      s_ack = ($urandom_range(0, 7) == 0);
      s_dat = $urandom;
      rst   = ($urandom_range(0, 199) == 0);
      cycle(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
